chunk_addsub: RTL and testbench
===============================

Name: chunk_addsub

Overview:
- Parametrised, multi-cycle successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit two's-complement operands CHUNK bits per clock, LSB chunk first, with a carry register between chunks.
- Uses a start/busy/done handshake and reports signed overflow, carry-out and zero flags.
- Sits in the CPU datapath as the ALU add/sub engine, where WIDTH is too wide for a single-cycle ripple chain.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH. N = WIDTH/CHUNK is the number of compute cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- sub  in  1  0: A+B, 1: A-B; latched with start
- A  in  WIDTH  operand A, latched with start
- B  in  WIDTH  operand B, latched with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid
- SUM  out  WIDTH  result, two's complement
- ovf  out  1  signed overflow
- cout  out  1  carry out of MSB (for subtract, 1 = no borrow)
- zero  out  1  SUM == 0

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; chunk counter and carry register clear.
  - busy, done, SUM, ovf, cout and zero all go to 0.
  - Any in-flight operation is aborted; no done is produced for it.
  - rst has priority over start.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on an edge where start=1 (call it edge k):
  - Latch opA=A and opB = sub ? ~B : B.
  - Set carry=sub and chunk index i=0.
  - busy=1 from edge k.
- RUN: at each edge k+1..k+N, chunk i is computed:
  - {c, s} = opA[i] + opB[i] + carry.
  - s is written to result bits [i*CHUNK +: CHUNK]; carry <= c; i increments.
  - At the last chunk, also capture the carry into the MSB bit (needed for ovf).
- RUN -> DONE at edge k+N. At that edge:
  - SUM, cout, ovf and zero update to the final values.
  - done=1 and busy=0.
  - Latency: done is high in the cycle after edge k+N, i.e. N+1 cycles after start is sampled.
- DONE lasts exactly one cycle. At the next edge, done clears and state goes to IDLE.
  - If start=1 in the DONE cycle, it is accepted as in IDLE: back-to-back operation, state goes to RUN.
- Flag rules:
  - ovf = carry into MSB XOR carry out of MSB.
  - cout = final carry.
  - zero = (SUM == 0).
  - Arithmetic is modulo 2^WIDTH.
- SUM and flags hold their values from done until the next completion or reset; they do not change during RUN.
- start while busy=1 is ignored. A, B and sub may change freely after the start edge.
- With CHUNK = WIDTH: N=1 and done appears 2 cycles after start.

Test Plan:
- WIDTH=8, CHUNK=4. start, A=0x03, B=0x04, sub=0 -> busy high for 2 cycles, then done pulse. SUM=0x07, ovf=0, cout=0, zero=0.
- WIDTH=8, CHUNK=4. A=0x05, B=0x07, sub=1 -> SUM=0xFE (-2), ovf=0, cout=0. Then A=0x80, B=0x01, sub=1 -> SUM=0x7F, ovf=1, cout=1.
- WIDTH=8, CHUNK=4. A=0x7F, B=0x01, sub=0 -> SUM=0x80, ovf=1. Then A=0xFF, B=0x01 -> SUM=0x00, zero=1, cout=1, ovf=0.
- WIDTH=4, CHUNK=1. A=0101, B=0110 -> done 5 cycles after start, SUM=1011, ovf=1. A=1101, B=1010 -> SUM=0111, ovf=1, cout=1.
- Handshake checks:
  - start re-asserted with new operands while busy -> ignored; the first result is unaffected.
  - start held high during the DONE cycle -> a second operation begins immediately; exactly one done per operation.
- Reset mid-operation: rst=1 during the second RUN cycle -> next cycle busy=0, done=0, SUM=0, all flags 0. No done follows. The next start computes correctly.

Source files
------------

// File: rtl/chunk_addsub.sv
// Multi-cycle two's-complement add/sub engine: CHUNK bits per clock, LSB chunk first,
// with start/busy/done handshake and ovf/cout/zero flags held until the next completion.
module chunk_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             ovf,
    output logic             cout,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] acc_next;
    logic             last;
    logic             cin_msb;

    // Operands shift right each cycle so the active chunk is always at the bottom;
    // the result fills in from the top and is fully aligned after N chunks.
    always_comb begin
        csum     = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + (CHUNK+1)'(carry);
        acc_next = (acc >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        last     = (idx == IW'(N - 1));
        // Carry into a bit is recovered from its sum bit and its two operand bits.
        cin_msb  = opa[CHUNK-1] ^ opb[CHUNK-1] ^ csum[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            SUM   <= '0;
            ovf   <= 1'b0;
            cout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= A;
                        opb   <= sub ? ~B : B;
                        carry <= sub;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    opa   <= opa >> CHUNK;
                    opb   <= opb >> CHUNK;
                    acc   <= acc_next;
                    carry <= csum[CHUNK];
                    idx   <= idx + IW'(1);
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        SUM   <= acc_next;
                        cout  <= csum[CHUNK];
                        ovf   <= cin_msb ^ csum[CHUNK];
                        zero  <= (acc_next == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_addsub.sv
// Directed bench for chunk_addsub: 8/4 and 4/1 configurations, vector table plus
// handshake, back-to-back and mid-operation reset sequences.
module tb_chunk_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, ovf8, cout8, zero8;

    logic       start4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic       busy4, done4, ovf4, cout4, zero4;

    int errors = 0;
    int checks = 0;
    int dcnt8  = 0;
    int dcnt4  = 0;

    chunk_addsub #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .SUM(sum8), .ovf(ovf8), .cout(cout8), .zero(zero8)
    );

    chunk_addsub #(.WIDTH(4), .CHUNK(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .SUM(sum4), .ovf(ovf4), .cout(cout4), .zero(zero4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done8) dcnt8++;
        if (done4) dcnt4++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       o;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_done8(input string nm, input int expl);
        int lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(expl));
    endtask

    task automatic wait_done4(input string nm, input int expl);
        int lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(expl));
    endtask

    task automatic op8(input string nm, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] esum, input logic eo, input logic ec, input logic ez);
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
        @(posedge clk); #1;
        check({nm, " busy"}, 32'(busy8), 32'(1));
        @(negedge clk);
        start8 = 1'b0; sub8 = ~s; a8 = 8'($urandom); b8 = 8'($urandom);
        wait_done8(nm, 2);
        check({nm, " sum"},  32'(sum8),  32'(esum));
        check({nm, " ovf"},  32'(ovf8),  32'(eo));
        check({nm, " cout"}, 32'(cout8), 32'(ec));
        check({nm, " zero"}, 32'(zero8), 32'(ez));
        check({nm, " busy at done"}, 32'(busy8), 32'(0));
        @(posedge clk); #1;
        check({nm, " done pulse"}, 32'(done8), 32'(0));
        check({nm, " sum held"},   32'(sum8),  32'(esum));
    endtask

    task automatic op4(input string nm, input logic s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] esum, input logic eo, input logic ec, input logic ez);
        @(negedge clk);
        start4 = 1'b1; sub4 = s; a4 = a; b4 = b;
        @(posedge clk); #1;
        check({nm, " busy"}, 32'(busy4), 32'(1));
        @(negedge clk);
        start4 = 1'b0; sub4 = ~s; a4 = ~a; b4 = ~b;
        wait_done4(nm, 4);
        check({nm, " sum"},  32'(sum4),  32'(esum));
        check({nm, " ovf"},  32'(ovf4),  32'(eo));
        check({nm, " cout"}, 32'(cout4), 32'(ec));
        check({nm, " zero"}, 32'(zero4), 32'(ez));
        @(posedge clk); #1;
        check({nm, " done pulse"}, 32'(done4), 32'(0));
    endtask

    initial begin
        int base;

        vecs[0] = '{1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h40, 8'h40, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 8'h12, 8'h34, 8'hDE, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy8", 32'(busy8), 32'(0));
        check("reset done8", 32'(done8), 32'(0));
        check("reset sum8",  32'(sum8),  32'(0));
        check("reset flags8", 32'({ovf8, cout8, zero8}), 32'(0));
        check("reset busy4", 32'(busy4), 32'(0));
        check("reset sum4/flags4", 32'({sum4, ovf4, cout4, zero4}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            op8($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                vecs[i].sum, vecs[i].o, vecs[i].c, vecs[i].z);

        op4("w4 add 5+6",   1'b0, 4'b0101, 4'b0110, 4'b1011, 1'b1, 1'b0, 1'b0);
        op4("w4 add -3-6",  1'b0, 4'b1101, 4'b1010, 4'b0111, 1'b1, 1'b1, 1'b0);
        op4("w4 sub 3-5",   1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0);

        // start while busy is ignored
        base = dcnt8;
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h03; b8 = 8'h04;
        @(posedge clk); #1;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; sub8 = 1'b1;
        @(posedge clk); #1;
        check("ignore busy mid", 32'(busy8), 32'(1));
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); #1;
        check("ignore done", 32'(done8), 32'(1));
        check("ignore sum",  32'(sum8),  32'(8'h07));
        repeat (4) @(posedge clk);
        #1;
        check("ignore done count", 32'(dcnt8 - base), 32'(1));
        check("ignore idle", 32'(busy8), 32'(0));

        // start held through DONE: back-to-back operations
        base = dcnt8;
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20;
        @(posedge clk); #1;
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h05; sub8 = 1'b1;
        wait_done8("b2b first", 2);
        check("b2b first sum", 32'(sum8), 32'(8'h30));
        check("b2b first flags", 32'({ovf8, cout8, zero8}), 32'(0));
        @(posedge clk); #1;
        check("b2b restart busy", 32'(busy8), 32'(1));
        check("b2b restart done", 32'(done8), 32'(0));
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("b2b second", 2);
        check("b2b second sum", 32'(sum8), 32'(8'hEB));
        check("b2b second flags", 32'({ovf8, cout8, zero8}), 32'(3'b010));
        repeat (4) @(posedge clk);
        #1;
        check("b2b done count", 32'(dcnt8 - base), 32'(2));

        // Reset during the second RUN cycle aborts the operation
        base = dcnt8;
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst busy", 32'(busy8), 32'(0));
        check("rst done", 32'(done8), 32'(0));
        check("rst sum",  32'(sum8),  32'(0));
        check("rst flags", 32'({ovf8, cout8, zero8}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst no done", 32'(dcnt8 - base), 32'(0));
        op8("post rst", 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
